// File: rtl/axi_master_arbiter.sv
//------------------------------------------------------------------------------
// axi_master_arbiter
//
// Purpose:
//    Shares the single command port of an AXI_master among NUM_REQ
//    independent requesters (DMA engine, register bridge, debug port, ...).
//    A round-robin search picks a winner out of the pending requests and
//    captures its command. The arbiter then runs the go/done level handshake
//    with the master and reports done/error and the data strobes back to the
//    granted requester only. It runs on the m_axi_aclk domain, directly above
//    AXI_master.
//
// Parameters:
//    NUM_REQ    - number of requesters (2..8; 1 gives a plain sequencer)
//    data_width - data width, must match AXI_master data_width
//    TIMEOUT    - ISSUE-state cycle limit before timeout_flag sets (0 = off)
//
// Ports:
//    m_axi_aclk, reset        - clock, asynchronous active-high reset
//    req / req_*              - per-requester level request and packed
//                               command fields (slice i of each packed bus)
//    req_write_data           - packed write data, forwarded live
//    grant                    - one-hot owner, IDLE exit to RELEASE exit
//    req_done / req_error     - one-cycle completion / error pulse to owner
//    read_data                - master read data, passed through
//    read_data_valid,
//    write_data_valid         - master strobes gated by grant
//    m_go, m_rnw, m_address,
//    m_burst_length,
//    m_burst_size,
//    m_increment_burst,
//    m_write_data             - command and write data toward the master
//    m_busy, m_done, m_error,
//    m_read_data,
//    m_read_data_valid,
//    m_write_data_valid       - status and strobes from the master
//    timeout_flag             - sticky watchdog flag
//    owner                    - binary index of the current or last owner
//------------------------------------------------------------------------------
module axi_master_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int data_width = 32,
   parameter int TIMEOUT    = 4096
) (
   input  logic                            m_axi_aclk,
   input  logic                            reset,

   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ-1:0]              req_rnw,
   input  logic [32*NUM_REQ-1:0]           req_address,
   input  logic [8*NUM_REQ-1:0]            req_burst_length,
   input  logic [7*NUM_REQ-1:0]            req_burst_size,
   input  logic [NUM_REQ-1:0]              req_increment_burst,
   input  logic [data_width*NUM_REQ-1:0]   req_write_data,

   output logic [NUM_REQ-1:0]              grant,
   output logic [NUM_REQ-1:0]              req_done,
   output logic [NUM_REQ-1:0]              req_error,
   output logic [data_width-1:0]           read_data,
   output logic [NUM_REQ-1:0]              read_data_valid,
   output logic [NUM_REQ-1:0]              write_data_valid,

   output logic                            m_go,
   output logic                            m_rnw,
   output logic                            m_increment_burst,
   output logic [31:0]                     m_address,
   output logic [7:0]                      m_burst_length,
   output logic [6:0]                      m_burst_size,
   output logic [data_width-1:0]           m_write_data,

   input  logic                            m_busy,
   input  logic                            m_done,
   input  logic                            m_error,
   input  logic [data_width-1:0]           m_read_data,
   input  logic                            m_read_data_valid,
   input  logic                            m_write_data_valid,

   output logic                            timeout_flag,
   output logic [2:0]                      owner
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   // The watchdog only has to count up to TIMEOUT and then saturates.
   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

   state_t                  r_state;
   state_t                  w_nextState;

   logic [NUM_REQ-1:0]      r_grant;
   logic [2:0]              r_owner;
   logic [2:0]              r_lastGrant;
   logic                    r_go;
   logic                    r_rnw;
   logic                    r_increment;
   logic [31:0]             r_address;
   logic [7:0]              r_burstLength;
   logic [6:0]              r_burstSize;
   logic [NUM_REQ-1:0]      r_reqDone;
   logic [NUM_REQ-1:0]      r_reqError;
   logic [WD_W-1:0]         r_watchdog;
   logic                    r_timeoutFlag;

   logic                    w_found;
   int                      w_cand;
   logic [2:0]              w_winner;
   logic [NUM_REQ-1:0]      w_winnerOneHot;
   logic                    w_selRnw;
   logic                    w_selIncrement;
   logic [31:0]             w_selAddress;
   logic [7:0]              w_selBurstLength;
   logic [6:0]              w_selBurstSize;

   logic                    w_capture;
   logic                    w_complete;
   logic                    w_release;
   logic [WD_W-1:0]         w_wdNext;
   logic [data_width-1:0]   w_writeData;
   logic                    w_unusedBusy;

   // The master's busy flag carries no information beyond the go/done
   // handshake, so it is deliberately left unconsumed.
   assign w_unusedBusy = m_busy;

   // Round-robin search: candidates are visited starting one past the last
   // owner and wrapping around, so the last owner itself is tried last. The
   // winner's command fields are selected alongside so capture is one step.
   always_comb begin
      w_found          = 1'b0;
      w_cand           = 0;
      w_winner         = '0;
      w_winnerOneHot   = '0;
      w_selRnw         = 1'b0;
      w_selIncrement   = 1'b0;
      w_selAddress     = '0;
      w_selBurstLength = '0;
      w_selBurstSize   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = int'(r_lastGrant) + k;
         if (w_cand >= NUM_REQ) begin
            w_cand = w_cand - NUM_REQ;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req[i] && (i == w_cand)) begin
               w_found           = 1'b1;
               w_winner          = 3'(i);
               w_winnerOneHot[i] = 1'b1;
               w_selRnw          = req_rnw[i];
               w_selIncrement    = req_increment_burst[i];
               w_selAddress      = req_address[i*32 +: 32];
               w_selBurstLength  = req_burst_length[i*8 +: 8];
               w_selBurstSize    = req_burst_size[i*7 +: 7];
            end
         end
      end
   end

   // State register.
   always_ff @(posedge m_axi_aclk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. RELEASE waits for the master to drop done, which
   // guarantees done is never still high when the next ISSUE begins.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_found) w_nextState = ISSUE;
         ISSUE:   if (m_done)  w_nextState = RELEASE;
         RELEASE: if (!m_done) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Output decode: one strobe per state transition, consumed by the
   // datapath registers below.
   always_comb begin
      w_capture  = 1'b0;
      w_complete = 1'b0;
      w_release  = 1'b0;
      case (r_state)
         IDLE:    w_capture  = w_found;
         ISSUE:   w_complete = m_done;
         RELEASE: w_release  = ~m_done;
         default: ;
      endcase
   end

   // Grant, captured command and completion pulses. The command is frozen
   // at capture so a requester may change its fields after being granted.
   // An error from the master is just a completion with the error bit set.
   always_ff @(posedge m_axi_aclk or posedge reset) begin
      if (reset) begin
         r_grant       <= '0;
         r_owner       <= '0;
         r_lastGrant   <= 3'(NUM_REQ - 1);
         r_go          <= 1'b0;
         r_rnw         <= 1'b0;
         r_increment   <= 1'b0;
         r_address     <= '0;
         r_burstLength <= '0;
         r_burstSize   <= '0;
         r_reqDone     <= '0;
         r_reqError    <= '0;
      end else begin
         r_reqDone  <= '0;
         r_reqError <= '0;
         if (w_capture) begin
            r_grant       <= w_winnerOneHot;
            r_owner       <= w_winner;
            r_lastGrant   <= w_winner;
            r_go          <= 1'b1;
            r_rnw         <= w_selRnw;
            r_increment   <= w_selIncrement;
            r_address     <= w_selAddress;
            r_burstLength <= w_selBurstLength;
            r_burstSize   <= w_selBurstSize;
         end
         if (w_complete) begin
            r_reqDone  <= r_grant;
            r_reqError <= r_grant & {NUM_REQ{m_error}};
            r_go       <= 1'b0;
         end
         if (w_release) begin
            r_grant <= '0;
         end
      end
   end

   assign w_wdNext = r_watchdog + WD_W'(1);

   // Watchdog: counts ISSUE cycles without completion and raises a sticky
   // flag once TIMEOUT is reached. The transaction keeps waiting regardless.
   always_ff @(posedge m_axi_aclk or posedge reset) begin
      if (reset) begin
         r_watchdog    <= '0;
         r_timeoutFlag <= 1'b0;
      end else if ((r_state == ISSUE) && !m_done) begin
         if (r_watchdog != WD_LIMIT) begin
            r_watchdog <= w_wdNext;
         end
         if ((TIMEOUT != 0) && (w_wdNext == WD_LIMIT)) begin
            r_timeoutFlag <= 1'b1;
         end
      end else begin
         r_watchdog <= '0;
      end
   end

   // Live write data from the current owner.
   always_comb begin
      w_writeData = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_owner == 3'(i)) begin
            w_writeData = req_write_data[i*data_width +: data_width];
         end
      end
   end

   assign grant             = r_grant;
   assign owner             = r_owner;
   assign req_done          = r_reqDone;
   assign req_error         = r_reqError;
   assign timeout_flag      = r_timeoutFlag;
   assign m_go              = r_go;
   assign m_rnw             = r_rnw;
   assign m_increment_burst = r_increment;
   assign m_address         = r_address;
   assign m_burst_length    = r_burstLength;
   assign m_burst_size      = r_burstSize;
   assign m_write_data      = w_writeData;
   assign read_data         = m_read_data;
   assign read_data_valid   = r_grant & {NUM_REQ{m_read_data_valid}};
   assign write_data_valid  = r_grant & {NUM_REQ{m_write_data_valid}};

endmodule
